// File: rtl/toggle_handshake_rx_pkg.sv
// Shared types and constants for the toggle-handshake receiver.
// Optional synchroniser feature: TOGGLE_HS_RX_SYNC_EN (see tgl_edge_detect).
package toggle_hs_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } toggle_hs_state_t;

    // Depth of the request synchroniser when it is built in.
    localparam int SYNC_DEPTH = 2;

    // Reset values of the single-bit state elements.
    localparam logic ACK_RST      = 1'b0;
    localparam logic VALID_RST    = 1'b0;
    localparam logic OVERRUN_RST  = 1'b0;
    localparam logic REQ_PREV_RST = 1'b0;
    localparam logic SYNC_RST     = 1'b0;

endpackage

// File: rtl/toggle_handshake_rx_if.sv
// Bundle of the toggle-handshake receiver's signals.
// master: producer/consumer side; slave: the receiver itself.
//
// Handshake rules:
//   Toggle side   - every level change of req_tgl is one event; data_in is
//                   stable from before that change until ack_tgl changes.
//   Valid/ready   - a word transfers on a rising edge where out_valid and
//                   out_ready are both high; out_valid never drops without
//                   such a transfer (except reset) and out_data is stable
//                   while out_valid is high.
interface toggle_handshake_rx_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) ();
    logic              req_tgl;
    logic [DATA_W-1:0] data_in;
    logic              ack_tgl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  event_count;
    logic              overrun_err;

    modport master (
        output req_tgl, data_in, out_ready,
        input  ack_tgl, out_valid, out_data, event_count, overrun_err
    );

    modport slave (
        input  req_tgl, data_in, out_ready,
        output ack_tgl, out_valid, out_data, event_count, overrun_err
    );
endinterface

// File: rtl/toggle_handshake_rx_tgl_edge_detect.sv
// Request toggle edge detector with an optional 2-flop synchroniser.
// Macro TOGGLE_HS_RX_SYNC_EN: when defined, req_tgl is synchronised
// before edge detection (2 extra cycles of latency).
module tgl_edge_detect
    import toggle_hs_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_tgl,
    output logic req_edge
);
    logic req_s;
    logic req_prev;

`ifdef TOGGLE_HS_RX_SYNC_EN
    logic [SYNC_DEPTH-1:0] sync_q;

    // Shift the asynchronous request through the synchroniser chain.
    always_ff @(posedge clk) begin
        if (rst) sync_q <= {SYNC_DEPTH{SYNC_RST}};
        else     sync_q <= {sync_q[SYNC_DEPTH-2:0], req_tgl};
    end

    assign req_s = sync_q[SYNC_DEPTH-1];
`else
    assign req_s = req_tgl;
`endif

    // Remember the last sampled request level.
    always_ff @(posedge clk) begin
        if (rst) req_prev <= REQ_PREV_RST;
        else     req_prev <= req_s;
    end

    assign req_edge = req_s ^ req_prev;
endmodule

// File: rtl/toggle_handshake_rx.sv
// Toggle-handshake receiver: captures one bundled word per request toggle,
// offers it on valid/ready, acks by toggling, counts events, flags overruns.
// Macro TOGGLE_HS_RX_SYNC_EN enables the request synchroniser.
module toggle_handshake_rx
    import toggle_hs_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    toggle_handshake_rx_if.slave bus,
    output toggle_hs_state_t state_dbg
);
    toggle_hs_state_t  state_q, state_d;
    logic              req_edge;
    logic              capture, consume, overrun;
    logic              ack_q, valid_q, overrun_q;
    logic [DATA_W-1:0] data_q;
    logic [CNT_W-1:0]  count_q;

    tgl_edge_detect u_edge (
        .clk      (clk),
        .rst      (rst),
        .req_tgl  (bus.req_tgl),
        .req_edge (req_edge)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state and per-cycle actions; an edge while holding is dropped.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        consume = 1'b0;
        overrun = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_edge) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (req_edge) overrun = 1'b1;
                if (valid_q && bus.out_ready) begin
                    consume = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers: word, valid, counter, ack toggle, sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q    <= '0;
            valid_q   <= VALID_RST;
            count_q   <= '0;
            ack_q     <= ACK_RST;
            overrun_q <= OVERRUN_RST;
        end else begin
            if (capture) begin
                data_q  <= bus.data_in;
                valid_q <= 1'b1;
                count_q <= count_q + 1'b1;
            end
            if (consume) begin
                valid_q <= 1'b0;
                ack_q   <= ~ack_q;
            end
            if (overrun) overrun_q <= 1'b1;
        end
    end

    assign bus.ack_tgl     = ack_q;
    assign bus.out_valid   = valid_q;
    assign bus.out_data    = data_q;
    assign bus.event_count = count_q;
    assign bus.overrun_err = overrun_q;
    assign state_dbg       = state_q;
endmodule

// File: tb/tb_toggle_handshake_rx.sv
// Directed bench for toggle_handshake_rx (default build, no synchroniser).
module tb_toggle_handshake_rx;
    import toggle_hs_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    toggle_hs_state_t state_dbg;

    toggle_handshake_rx_if #(.DATA_W(8), .CNT_W(8)) bus ();

    toggle_handshake_rx #(.DATA_W(8), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // Clock.
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       req;
        logic [7:0] data;
        logic       ready;
        logic       e_valid;
        logic [7:0] e_data;
        logic       e_ack;
        logic [7:0] e_cnt;
        logic       e_ovr;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic void add(logic r, logic q, logic [7:0] d, logic rdy,
                                logic ev, logic [7:0] ed, logic ea,
                                logic [7:0] ec, logic eo);
        vec_t v;
        v.rst = r; v.req = q; v.data = d; v.ready = rdy;
        v.e_valid = ev; v.e_data = ed; v.e_ack = ea; v.e_cnt = ec; v.e_ovr = eo;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(logic r, logic q, logic [7:0] d, logic rdy);
        rst           = r;
        bus.req_tgl   = q;
        bus.data_in   = d;
        bus.out_ready = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic req;
        drive(1'b1, 1'b0, 8'h00, 1'b0);

        //   rst req data  rdy | valid data  ack cnt   ovr
        // Reset, then 5 idle cycles.
        add(1, 0, 8'h00, 0,   0, 8'h00, 0, 8'd0, 0);
        add(1, 0, 8'h00, 0,   0, 8'h00, 0, 8'd0, 0);
        for (int i = 0; i < 5; i++) add(0, 0, 8'h00, 0, 0, 8'h00, 0, 8'd0, 0);
        // Single event 0xA5 with ready high.
        add(0, 1, 8'hA5, 1,   1, 8'hA5, 0, 8'd1, 0);
        add(0, 1, 8'hA5, 1,   0, 8'hA5, 1, 8'd1, 0);
        add(0, 1, 8'hA5, 0,   0, 8'hA5, 1, 8'd1, 0);
        // Backpressure on 0x3C for 4 cycles, then release.
        add(0, 0, 8'h3C, 0,   1, 8'h3C, 1, 8'd2, 0);
        for (int i = 0; i < 4; i++) add(0, 0, 8'h3C, 0, 1, 8'h3C, 1, 8'd2, 0);
        add(0, 0, 8'h3C, 1,   0, 8'h3C, 0, 8'd2, 0);
        add(0, 0, 8'h3C, 0,   0, 8'h3C, 0, 8'd2, 0);
        // Overrun: 0x22 arrives while 0x11 is held.
        add(1, 0, 8'h00, 0,   0, 8'h00, 0, 8'd0, 0);
        add(0, 1, 8'h11, 0,   1, 8'h11, 0, 8'd1, 0);
        add(0, 0, 8'h22, 0,   1, 8'h11, 0, 8'd1, 1);
        add(0, 0, 8'h22, 1,   0, 8'h11, 1, 8'd1, 1);
        add(0, 0, 8'h22, 0,   0, 8'h11, 1, 8'd1, 1);
        // Edge coincident with consume: overrun, consume completes, event dropped.
        add(1, 0, 8'h00, 0,   0, 8'h00, 0, 8'd0, 0);
        add(0, 1, 8'h33, 0,   1, 8'h33, 0, 8'd1, 0);
        add(0, 0, 8'h44, 1,   0, 8'h33, 1, 8'd1, 1);
        add(0, 0, 8'h44, 1,   0, 8'h33, 1, 8'd1, 1);
        // Back-to-back with ready tied high: events every 2 cycles.
        add(0, 1, 8'h55, 1,   1, 8'h55, 1, 8'd2, 1);
        add(0, 1, 8'h55, 1,   0, 8'h55, 0, 8'd2, 1);
        add(0, 0, 8'h66, 1,   1, 8'h66, 0, 8'd3, 1);
        add(0, 0, 8'h66, 1,   0, 8'h66, 1, 8'd3, 1);
        // Mid-operation reset while holding with ack=1.
        add(0, 1, 8'h77, 0,   1, 8'h77, 1, 8'd4, 1);
        add(1, 1, 8'h77, 0,   0, 8'h00, 0, 8'd0, 0);
        // Release with req high: one event detected, then normal traffic.
        add(0, 1, 8'h88, 0,   1, 8'h88, 0, 8'd1, 0);
        add(0, 1, 8'h88, 1,   0, 8'h88, 1, 8'd1, 0);
        add(0, 0, 8'h99, 1,   1, 8'h99, 1, 8'd2, 0);
        add(0, 0, 8'h99, 1,   0, 8'h99, 0, 8'd2, 0);

        foreach (vecs[k]) begin
            drive(vecs[k].rst, vecs[k].req, vecs[k].data, vecs[k].ready);
            step();
            check("out_valid",   k, {31'd0, bus.out_valid},   {31'd0, vecs[k].e_valid});
            check("out_data",    k, {24'd0, bus.out_data},    {24'd0, vecs[k].e_data});
            check("ack_tgl",     k, {31'd0, bus.ack_tgl},     {31'd0, vecs[k].e_ack});
            check("event_count", k, {24'd0, bus.event_count}, {24'd0, vecs[k].e_cnt});
            check("overrun_err", k, {31'd0, bus.overrun_err}, {31'd0, vecs[k].e_ovr});
            check("state_dbg",   k, {31'd0, state_dbg},
                  {31'd0, (vecs[k].e_valid ? HOLD : IDLE)});
        end

        // Counter wrap: 256 acked events from a clean reset.
        drive(1'b1, 1'b0, 8'h00, 1'b1);
        step();
        req = 1'b0;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] d;
            logic [7:0] c;
            d = i[7:0];
            c = 8'(i + 1);
            req = ~req;
            drive(1'b0, req, d, 1'b1);
            step();
            check("wrap_valid", i, {31'd0, bus.out_valid}, 32'd1);
            check("wrap_data",  i, {24'd0, bus.out_data}, {24'd0, d});
            check("wrap_count", i, {24'd0, bus.event_count}, {24'd0, c});
            step();
            check("wrap_ack", i, {31'd0, bus.ack_tgl}, {31'd0, ~i[0]});
        end
        check("wrap_final_count", 0, {24'd0, bus.event_count}, 32'd0);
        check("wrap_final_ack",   0, {31'd0, bus.ack_tgl},     32'd0);
        check("wrap_final_valid", 0, {31'd0, bus.out_valid},   32'd0);
        check("wrap_final_ovr",   0, {31'd0, bus.overrun_err}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/toggle_handshake_rx.md
# toggle_handshake_rx

Receiving end of the two-phase (toggle) handshake whose transmitter drives its request line from a T flip-flop: every event flips `req_tgl` instead of pulsing it. This block detects each toggle, captures the bundled data word, and presents it downstream on a valid/ready port. It acknowledges consumption by flipping `ack_tgl`, and it counts accepted events and flags protocol overruns. It sits between a toggle-signalling producer and any valid/ready consumer in the same clock domain, or in a foreign clock domain when synchronisation is enabled.

## Interface
- `DATA_W`, default 8: width of bundled data word.
- `CNT_W`, default 8: width of the accepted-event counter.
- `clk` input, 1 bit: single clock; all state updates on rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `req_tgl` input, 1 bit: request toggle; each level change is one event.
- `data_in` input, `DATA_W` bits: bundled data; stable from before the `req_tgl` flip until the matching `ack_tgl` flip.
- `ack_tgl` output, 1 bit: acknowledge toggle; flips once per consumed event.
- `out_valid` output, 1 bit: `out_data` holds an unconsumed word.
- `out_ready` input, 1 bit: downstream accepts the word when high together with `out_valid`.
- `out_data` output, `DATA_W` bits: captured word.
- `event_count` output, `CNT_W` bits: number of accepted events, modulo 2^`CNT_W`.
- `overrun_err` output, 1 bit: sticky; a toggle arrived while a word was still held.

## Operation
- Reset values: `ack_tgl`=0, `out_valid`=0, `out_data`=0, `event_count`=0, `overrun_err`=0, `req_prev`=0, synchroniser flops=0, state=IDLE. The transmitter's toggle flop must also reset to 0. If `req_tgl`=1 at reset release, one event is detected, and that is correct behaviour.
- Edge detect: `req_edge = req_s ^ req_prev`. `req_s` is `req_tgl` itself, or the synchroniser output when enabled. `req_prev <= req_s` every cycle.
- State IDLE: on `req_edge`, set `out_data <= data_in`, `out_valid <= 1`, `event_count <= event_count+1` (wraps silently), then go to HOLD.
- State HOLD: when `out_valid && out_ready`, set `out_valid <= 0`, `ack_tgl <= ~ack_tgl`, then go to IDLE.
- Overrun: if `req_edge` occurs in HOLD, set `overrun_err <= 1`. The event is discarded: no capture, no count, no ack. HOLD continues normally. Only `rst` clears `overrun_err`.
- Simultaneous edge and consume in the same HOLD cycle counts as an overrun. The consume still completes. The new event is dropped.
- `rst` asserted mid-operation overrides everything on that edge. A held word is lost and `ack_tgl` returns to 0.

## Timing
- Without sync: `req_tgl` flips before edge N, `req_edge` is high in cycle N, and `out_valid` and `out_data` are visible after edge N (1-cycle latency).
- With sync: latency is 3 cycles from the `req_tgl` flip to `out_valid`.
- `ack_tgl` flips on the edge following the cycle in which `out_valid && out_ready`. `out_valid` falls on the same edge.
- Back-to-back throughput: with `out_ready` tied high, `out_valid` stays high for one cycle and the next event is accepted from IDLE on the following cycle. The minimum event spacing is 2 cycles (no sync).
- `out_data` holds its value after consumption until the next capture.

## Configuration
- Macro: `TOGGLE_HS_RX_SYNC_EN`.
- Defined: `req_tgl` passes through a 2-flop synchroniser before edge detection, which adds 2 cycles of latency. `data_in` is not synchronised; it relies on the bundled-data stability rule.
- Undefined: `req_tgl` is used directly and must be synchronous to `clk`.

## Structure
- Package `toggle_hs_pkg` contains:
  - the state enum typedef `toggle_hs_state_t` (IDLE, HOLD);
  - localparams for reset values and synchroniser depth (2).
- Sub-module `tgl_edge_detect`, which contains:
  - the optional synchroniser (macro-gated);
  - the `req_prev` flop;
  - the `req_edge` output.
- The top level holds the FSM, data register, counter, ack flop and error flag.

## Test plan
- Reset: assert `rst` for 2 cycles with `req_tgl`=0. Required: all outputs 0, `out_valid`=0 for 5 idle cycles.
- Single event: `data_in`=0xA5, flip `req_tgl` 0→1, `out_ready`=1. Required: `out_valid`=1 and `out_data`=0xA5 one cycle later (three with sync); `ack_tgl`=1 on the next edge; `event_count`=1.
- Backpressure: `out_ready`=0 for 4 cycles after capture of 0x3C. Required: `out_valid` and `out_data` stable and `ack_tgl` unchanged; `ack_tgl` flips one edge after `out_ready` rises.
- Overrun: capture 0x11, hold `out_ready`=0, flip `req_tgl` again with `data_in`=0x22. Required: `overrun_err`=1, `out_data` stays 0x11, `event_count`=1.
- Counter wrap: with `CNT_W`=8, drive 256 properly acked events. Required: `event_count` returns to 0 and `ack_tgl` ends at 0.
- Mid-operation reset: assert `rst` while in HOLD with `ack_tgl`=1. Required: all outputs return to their reset values on that edge, and the next toggle is captured normally.
